// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, pixel type and the padded-word unpack helper.
// Used by the VGA read path.
package fb_pkg;

    localparam int unsigned SRC_W    = 320;
    localparam int unsigned SRC_H    = 240;
    localparam int unsigned FB_DEPTH = SRC_W * SRC_H;
    localparam int unsigned ADDR_W   = 17;

    typedef enum logic {
        StWaitFrame,
        StRun
    } fb_state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Stored word is {r[3:0], pad, g[3:0], pad, pad, b[3:0], pad}.
    function automatic rgb444_t unpack(input logic [15:0] word);
        rgb444_t px;
        logic    pad_unused;
        pad_unused = ^{word[11], word[6:5], word[0]};
        px.r = word[15:12];
        px.g = word[10:7];
        px.b = word[4:1];
        return px;
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// Frame-buffer read port: address/enable from the reader, registered data back.
interface vga_fb_reader_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [ADDR_W-1:0] rAddr;
    logic              oe;
    logic [15:0]       rData;

    modport master (output rAddr, output oe, input rData);
    modport slave  (input rAddr, input oe, output rData);
endinterface

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value; keeps syncs aligned with
// pipelined pixel data. N must be at least 2.
module sync_delay #(
    parameter int unsigned N       = 3,
    parameter int unsigned W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [N-1:0][W-1:0] stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= {N{RST_VAL}};
        end else begin
            stage_q <= {stage_q[N-2:0], din};
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer read master: 2x2 upscales a 320x240 buffer onto 640x480 VGA timing,
// generating addresses incrementally and realigning syncs with the pixel data.
module vga_fb_reader #(
    parameter int unsigned SRC_W    = 320,
    parameter int unsigned SRC_H    = 240,
    parameter int unsigned ADDR_W   = 17,
    parameter logic        SYNC_ACT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     h_sync_in,
    input  logic                     v_sync_in,
    input  logic                     de_in,
    vga_fb_reader_if.master          fb,
    output logic                     h_sync,
    output logic                     v_sync,
    output logic                     de,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue
);
    import fb_pkg::*;

    localparam int unsigned HCNT_W = $clog2(2 * SRC_W);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(2 * SRC_W - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((SRC_H - 1) * SRC_W);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SRC_W);

    fb_state_e         state_q, state_d;
    logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
    logic              line_cnt_q, line_cnt_d;  // only the pair parity is ever needed
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              oe_q, oe_d;
    logic              oe_dly_q;
    logic              vs_prev_q, de_prev_q;
    rgb444_t           rgb_q;
    logic [2:0]        sync_dly;

    logic vs_edge, de_fall;
    assign vs_edge = (v_sync_in == SYNC_ACT) && (vs_prev_q != SYNC_ACT);
    assign de_fall = de_prev_q && !de_in;

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        line_cnt_d  = line_cnt_q;
        line_base_d = line_base_q;
        raddr_d     = line_base_q + ADDR_W'(h_cnt_q[HCNT_W-1:1]);
        oe_d        = de_in && (state_q == StRun);
        if (vs_edge) begin
            // A pixel coinciding with the edge already reads from the top of the frame.
            state_d     = StRun;
            h_cnt_d     = '0;
            line_cnt_d  = 1'b0;
            line_base_d = '0;
            raddr_d     = '0;
        end else if (state_q == StRun) begin
            if (de_fall) begin
                h_cnt_d    = '0;
                line_cnt_d = ~line_cnt_q;
                if (line_cnt_q && (line_base_q < LAST_BASE)) begin
                    line_base_d = line_base_q + ROW_STEP;
                end
            end else if (de_in && (h_cnt_q != HCNT_MAX)) begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StWaitFrame;
            h_cnt_q     <= '0;
            line_cnt_q  <= 1'b0;
            line_base_q <= '0;
            raddr_q     <= '0;
            oe_q        <= 1'b0;
            oe_dly_q    <= 1'b0;
            vs_prev_q   <= ~SYNC_ACT;
            de_prev_q   <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_base_q <= line_base_d;
            raddr_q     <= raddr_d;
            oe_q        <= oe_d;
            oe_dly_q    <= oe_q;
            vs_prev_q   <= v_sync_in;
            de_prev_q   <= de_in;
            rgb_q       <= oe_dly_q ? unpack(fb.rData) : '0;
        end
    end

    assign fb.rAddr = raddr_q;
    assign fb.oe    = oe_q;

    sync_delay #(
        .N       (3),
        .W       (3),
        .RST_VAL ({~SYNC_ACT, ~SYNC_ACT, 1'b0})
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({h_sync_in, v_sync_in, de_in}),
        .dout  (sync_dly)
    );

    assign h_sync = sync_dly[2];
    assign v_sync = sync_dly[1];
    assign de     = sync_dly[0];
    assign red    = rgb_q.r;
    assign green  = rgb_q.g;
    assign blue   = rgb_q.b;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: address generation, upscaling, saturation,
// pipeline alignment, blanking and reset behaviour against a small frame-buffer model.
module tb_vga_fb_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       h_sync_in = 1'b1;
    logic       v_sync_in = 1'b1;
    logic       de_in = 1'b0;
    logic       h_sync, v_sync, de;
    logic [3:0] red, green, blue;
    logic       force_ff = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int max_addr = 0;
    int f_addr, l_addr;

    always #20 clk = ~clk;

    vga_fb_reader_if #(.ADDR_W(17)) fb ();

    vga_fb_reader #(
        .SRC_W    (320),
        .SRC_H    (240),
        .ADDR_W   (17),
        .SYNC_ACT (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .de_in     (de_in),
        .fb        (fb),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .de        (de),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // Frame-buffer model: one-cycle registered read.
    always @(posedge clk) begin
        if (force_ff) begin
            fb.rData <= 16'hFFFF;
        end else if (fb.oe) begin
            fb.rData <= (fb.rAddr == 17'd5) ? 16'hF83E : 16'h1234 + fb.rAddr[15:0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        de_in     = 1'b0;
        v_sync_in = 1'b0;
        step();
        step();
        v_sync_in = 1'b1;
        step();
    endtask

    task automatic run_line(input int n, output int first, output int last);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b1;
            step();
            if (i == 0) first = int'(fb.rAddr);
            last = int'(fb.rAddr);
            if (int'(fb.rAddr) > max_addr) max_addr = int'(fb.rAddr);
        end
        de_in = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check_eq("rst_raddr", 32'(fb.rAddr), 32'd0);
        check_eq("rst_oe", 32'(fb.oe), 32'd0);
        check_eq("rst_rgb", 32'({red, green, blue}), 32'd0);
        check_eq("rst_de", 32'(de), 32'd0);
        check_eq("rst_hs", 32'(h_sync), 32'd1);
        check_eq("rst_vs", 32'(v_sync), 32'd1);
        reset = 1'b0;

        // WAIT_FRAME ignores de_in
        for (int i = 0; i < 4; i++) begin
            de_in = 1'b1;
            step();
            check_eq("wait_oe", 32'(fb.oe), 32'd0);
        end
        check_eq("wait_de_dly", 32'(de), 32'd1);
        check_eq("wait_rgb", 32'({red, green, blue}), 32'd0);
        de_in = 1'b0;
        repeat (4) step();

        // Full frame with overlong tail
        vsync_pulse();
        run_line(640, f_addr, l_addr);
        check_eq("l0_first", 32'(f_addr), 32'd0);
        check_eq("l0_last", 32'(l_addr), 32'd319);
        run_line(640, f_addr, l_addr);
        check_eq("l1_first", 32'(f_addr), 32'd0);
        run_line(640, f_addr, l_addr);
        check_eq("l2_first", 32'(f_addr), 32'd320);
        check_eq("l2_last", 32'(l_addr), 32'd639);
        for (int ln = 3; ln < 479; ln++) run_line(2, f_addr, l_addr);
        run_line(640, f_addr, l_addr);
        check_eq("l479_first", 32'(f_addr), 32'd76480);
        check_eq("l479_last", 32'(l_addr), 32'd76799);
        for (int ln = 480; ln < 489; ln++) run_line(2, f_addr, l_addr);
        run_line(700, f_addr, l_addr);
        check_eq("l489_first", 32'(f_addr), 32'd76480);
        check_eq("l489_last", 32'(l_addr), 32'd76799);
        check_eq("max_addr", 32'(max_addr), 32'd76799);
        check_eq("blank_raddr_max", 32'(int'(fb.rAddr) <= 76799), 32'd1);

        // Pixel pipeline: address 5 -> F83E, address 4 -> 1238
        vsync_pulse();
        for (int i = 0; i < 14; i++) begin
            de_in = 1'b1;
            step();
            if (i == 10) begin
                check_eq("p8_red", 32'(red), 32'h1);
                check_eq("p8_green", 32'(green), 32'h4);
                check_eq("p8_blue", 32'(blue), 32'hC);
            end
            if (i == 12) begin
                check_eq("p10_red", 32'(red), 32'hF);
                check_eq("p10_green", 32'(green), 32'h0);
                check_eq("p10_blue", 32'(blue), 32'hF);
                check_eq("p10_de", 32'(de), 32'd1);
            end
        end
        de_in = 1'b0;
        repeat (4) step();

        // Single-cycle de pulse at start of line 1 (base still 0): address 0 -> 1234
        de_in = 1'b1;
        step();
        check_eq("pulse_raddr", 32'(fb.rAddr), 32'd0);
        check_eq("pulse_oe", 32'(fb.oe), 32'd1);
        de_in = 1'b0;
        step();
        check_eq("pulse_de_early", 32'(de), 32'd0);
        step();
        check_eq("pulse_de", 32'(de), 32'd1);
        check_eq("pulse_rgb", 32'({red, green, blue}), 32'h14A);
        step();
        check_eq("pulse_de_end", 32'(de), 32'd0);
        check_eq("pulse_rgb_end", 32'({red, green, blue}), 32'd0);
        repeat (3) step();

        // Blanking with all-ones data; sync delay of exactly 3
        force_ff  = 1'b1;
        repeat (4) step();
        h_sync_in = 1'b0;
        step();
        check_eq("hs_d1", 32'(h_sync), 32'd1);
        step();
        check_eq("hs_d2", 32'(h_sync), 32'd1);
        check_eq("blank_rgb", 32'({red, green, blue}), 32'd0);
        step();
        check_eq("hs_d3", 32'(h_sync), 32'd0);
        h_sync_in = 1'b1;
        repeat (3) step();
        v_sync_in = 1'b0;
        step();
        step();
        check_eq("vs_d2", 32'(v_sync), 32'd1);
        step();
        check_eq("vs_d3", 32'(v_sync), 32'd0);
        check_eq("blank_rgb2", 32'({red, green, blue}), 32'd0);
        v_sync_in = 1'b1;
        force_ff  = 1'b0;
        repeat (4) step();

        // v_sync mid-line on line 2 at h_cnt = 100
        vsync_pulse();
        run_line(640, f_addr, l_addr);
        run_line(640, f_addr, l_addr);
        for (int i = 0; i < 100; i++) begin
            de_in = 1'b1;
            step();
        end
        check_eq("mid_pre_addr", 32'(fb.rAddr), 32'd369);
        v_sync_in = 1'b0;
        step();
        step();
        check_eq("mid_next_addr", 32'(fb.rAddr), 32'd0);
        v_sync_in = 1'b1;
        de_in = 1'b0;
        repeat (4) step();
        run_line(4, f_addr, l_addr);
        check_eq("mid_next_base", 32'(f_addr), 32'd0);

        // Asynchronous reset mid-RUN with de_in high
        vsync_pulse();
        de_in = 1'b1;
        step();
        step();
        check_eq("pre_rst_oe", 32'(fb.oe), 32'd1);
        #5;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_oe", 32'(fb.oe), 32'd0);
        check_eq("mid_rst_raddr", 32'(fb.rAddr), 32'd0);
        check_eq("mid_rst_de", 32'(de), 32'd0);
        check_eq("mid_rst_hs", 32'(h_sync), 32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("post_rst_oe", 32'(fb.oe), 32'd0);
        end
        check_eq("post_rst_rgb", 32'({red, green, blue}), 32'd0);
        vsync_pulse();
        de_in = 1'b1;
        step();
        check_eq("resume_oe", 32'(fb.oe), 32'd1);
        check_eq("resume_raddr", 32'(fb.rAddr), 32'd0);
        de_in = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Read-side master for the 320x240 frame buffer. Consumes 640x480 VGA timing (hsync, vsync, DE) from the sync generator.
- Generates rAddr/oe for the frame buffer with 2x2 pixel upscaling, using incremental address generation (no multiplier).
- Unpacks the padded 16-bit read word to RGB444 and realigns the syncs so the DAC sees pixel and syncs on the same cycle.

Parameters:
- SRC_W, 320, source frame width in pixels.
- SRC_H, 240, source frame height in lines.
- ADDR_W, 17, frame buffer address width.
- SYNC_ACT, 1'b0, active level of h_sync_in/v_sync_in (VGA 640x480 is active-low).

Ports:
- clk  in  1  pixel clock (25 MHz); also drives frame buffer rclk.
- reset  in  1  asynchronous, active-high reset.
- h_sync_in  in  1  horizontal sync from the sync generator.
- v_sync_in  in  1  vertical sync from the sync generator.
- de_in  in  1  display enable; high during the 640x480 active area.
- rAddr  out  ADDR_W  frame buffer read address.
- oe  out  1  frame buffer read enable.
- rData  in  16  frame buffer read data; valid 1 cycle after rAddr/oe are registered.
- h_sync  out  1  h_sync_in delayed 3 cycles.
- v_sync  out  1  v_sync_in delayed 3 cycles.
- de  out  1  de_in delayed 3 cycles.
- red  out  4  pixel red; 0 when de is low.
- green  out  4  pixel green; 0 when de is low.
- blue  out  4  pixel blue; 0 when de is low.

Behaviour:
- Reset (async, active-high) clears every register:
  - rAddr=0, oe=0, RGB=0, de=0.
  - h_sync and v_sync reset to the inactive level (~SYNC_ACT).
  - Internal counters reset to 0, FSM to WAIT_FRAME.
- FSM:
  - WAIT_FRAME: oe is held 0 and RGB outputs are 0, even while de_in is high. On the first v_sync_in transition to SYNC_ACT, go to RUN.
  - RUN: free-running. Every active edge of v_sync_in clears line_base, line_cnt and h_cnt; the FSM stays in RUN.
- Per-pixel address generation:
  - h_cnt counts de_in-high cycles within a line and saturates at 2*SRC_W-1.
  - col = h_cnt>>1.
  - Next address = line_base + col, computed as a 17-bit add with no overflow possible inside range.
- Per-line update, on the de_in falling edge:
  - h_cnt clears; line_cnt increments.
  - When line_cnt's LSB was 1 (second line of a pair), line_base += SRC_W.
  - line_base saturates at (SRC_H-1)*SRC_W (76480). Extra lines repeat the last row and never produce an address above 76799.
- Pipeline, with a pixel whose de_in is sampled at edge t:
  - t+1: rAddr and oe are registered (oe=de_in & RUN).
  - t+2: the frame buffer registers the data.
  - t+3: red, green and blue are registered.
  - h_sync, v_sync and de are delayed through a matched 3-stage shift register. Sync-to-pixel skew is 0.
- Unpack: red=rData[15:12], green=rData[10:7], blue=rData[4:1]. Padding bits are ignored.
- When de is low at t+3, RGB is forced to 0 irrespective of rData (blanking).
- Boundary conditions:
  - de_in high for more than 640 cycles: the last column repeats.
  - de_in pulse of 1 cycle: a valid single pixel.
  - v_sync active during an active line: counters clear immediately, and the next pixel reads address 0.
  - Reset mid-frame: returns to WAIT_FRAME; no output until the next v_sync.

Decomposition:
- Shared package fb_pkg holds:
  - SRC_W, SRC_H, FB_DEPTH=76800 and ADDR_W constants.
  - An rgb444_t packed struct {r,g,b}.
  - An unpack function mapping 16-bit padded data to rgb444_t.
- One natural sub-module, sync_delay: an N-stage shift register with a per-bit reset value, used here with N=3 for {h_sync, v_sync, de}.

Test Plan:
1. Reset mid-RUN with de_in high -> all outputs reset immediately; oe stays 0 until the next v_sync active edge.
2. First frame: pixel 0 of line 0 -> rAddr=0; pixel 639 -> rAddr=319; line 1 pixel 0 -> rAddr=0; line 2 pixel 0 -> rAddr=320; line 479 pixel 639 -> rAddr=76799.
3. Model frame buffer returning rData=16'hF83E for address 5 -> at pixel t with col 5, red=F, green=0, blue=F on edge t+3, aligned with de=1 and unchanged sync delay.
4. de_in low during blanking with rData=16'hFFFF -> RGB=0; h_sync and v_sync at outputs exactly 3 cycles after the inputs.
5. Overlong line (700 de cycles) and 490 lines -> rAddr never exceeds 76799; the last column and last row repeat.
6. v_sync asserted mid-line at h_cnt=100 -> next de pixel drives rAddr=0; line_base is 0 on the following line.
